// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: instruction geometry and the
// instruction-memory loader state encoding.
package mips_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_full pulses
// combinationally on the handshake that completes a word.
module byte_packer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (clr) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (byte_en) begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = {shreg_q[WORD_W-9:0], byte_in};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    assign word      = shreg_q;
    assign word_full = byte_en && !clr && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a byte stream, writes packed words to
// imem and holds the core in reset until the requested word count is written.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [7:0]        checksum
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(2 ** ADDR_W);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              err_q, err_d;
    logic [7:0]        checksum_q, checksum_d;

    logic start_accept, oversize, go_recv, last_word, byte_en, word_full;

    assign start_accept = load_start && (state_q == IDLE || state_q == DONE);
    assign oversize     = load_words > DEPTH;
    assign go_recv      = start_accept && !oversize && (load_words != '0);
    assign last_word    = ({1'b0, addr_q} == (words_q - 1'b1));
    assign byte_en      = byte_valid && byte_ready;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (go_recv),
        .byte_en   (byte_en),
        .byte_in   (byte_data),
        .word      (imem_wdata),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            words_q    <= '0;
            err_q      <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            err_q      <= err_d;
            checksum_q <= checksum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_accept) begin
                    if (oversize)                state_d = IDLE;
                    else if (load_words == '0)   state_d = DONE;
                    else                         state_d = RECV;
                end
            end
            RECV:    if (word_full) state_d = WRITE;
            WRITE:   state_d = last_word ? DONE : RECV;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state_q == RECV);
        imem_we    = (state_q == WRITE);
        core_rst   = (state_q != DONE);
        done       = (state_q == DONE);
    end

    // Address wraps after a full-depth load; that final increment is never used.
    always_comb begin
        addr_d     = addr_q;
        words_d    = words_q;
        checksum_d = checksum_q;
        err_d      = err_q | (start_accept && oversize);
        if (go_recv) begin
            addr_d     = '0;
            words_d    = load_words;
            checksum_d = '0;
        end else begin
            if (state_q == WRITE) addr_d = addr_q + 1'b1;
            if (byte_en)          checksum_d = checksum_q + byte_data;
        end
    end

    assign imem_addr = addr_q;
    assign err       = err_q;
    assign checksum  = checksum_q;

endmodule
